// File: rtl/instruction_loader.sv
// instruction_loader
//   Writer side of the instruction-memory interface. Receives a program as a
//   byte stream (16-bit big-endian word count N, then 4*N bytes, each word
//   big-endian), packs the bytes into 32-bit words and writes them to
//   instruction memory starting at word address 0. The processor is held in
//   reset until a complete, well-formed program has been written.
//
//   Optional feature, enabled by defining OPCODE_CHECK_EN: every written
//   word's opcode field [31:26] is checked against the supported MIPS subset.
//   An unsupported opcode sets a sticky illegal_op flag and the session ends
//   in ERROR instead of DONE. Without the macro, illegal_op is tied to 0.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   start         begins a load session (sampled in IDLE, DONE, ERROR only)
//   byte_in       stream byte
//   byte_valid    byte_in valid
//   byte_ready    loader accepts a byte this cycle
//   mem_we        one-cycle write strobe per word
//   mem_addr      word address for the write
//   mem_wdata     instruction word for the write
//   cpu_hold      keeps the processor in reset while high
//   load_done     program loaded successfully (level)
//   load_error    session aborted (level)
//   words_written words written in this session
//   illegal_op    sticky unsupported-opcode flag

module instruction_loader #(
  parameter int MEMORY_DEPTH = 64,
  parameter int ADDR_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic                  illegal_op
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR
  } stateT;

  stateT       state;
  logic [7:0]  lenHi;
  logic [15:0] wordCount;
  logic [1:0]  byteIdx;
  logic [23:0] shiftReg;

  logic        take;
  logic [15:0] lenWord;
  logic [15:0] writtenNext;
  logic        badOpcode;
  logic        finalBad;

  assign take        = byte_valid && byte_ready;
  assign lenWord     = {lenHi, byte_in};
  assign writtenNext = 16'(words_written) + 16'd1;

`ifdef OPCODE_CHECK_EN
  logic illegalSeen;

  // mem_wdata holds the word being written while in WRITE.
  always_comb begin
    badOpcode = 1'b1;
    case (mem_wdata[31:26])
      6'h00, 6'h08, 6'h0d, 6'h0c, 6'h0f, 6'h23,
      6'h2b, 6'h04, 6'h05, 6'h02, 6'h03: badOpcode = 1'b0;
      default:                           badOpcode = 1'b1;
    endcase
  end

  // The final word's own check must count, so look at it before it lands
  // in the sticky flag.
  assign finalBad   = illegalSeen | badOpcode;
  assign illegal_op = illegalSeen;
`else
  assign badOpcode  = 1'b0;
  assign finalBad   = 1'b0;
  assign illegal_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      byte_ready    <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      cpu_hold      <= 1'b1;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
      words_written <= '0;
      lenHi         <= '0;
      wordCount     <= '0;
      byteIdx       <= '0;
      shiftReg      <= '0;
`ifdef OPCODE_CHECK_EN
      illegalSeen   <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state         <= LEN_HI;
            byte_ready    <= 1'b1;
            cpu_hold      <= 1'b1;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
            words_written <= '0;
            byteIdx       <= '0;
`ifdef OPCODE_CHECK_EN
            illegalSeen   <= 1'b0;
`endif
          end
        end

        LEN_HI: begin
          if (take) begin
            lenHi <= byte_in;
            state <= LEN_LO;
          end
        end

        LEN_LO: begin
          if (take) begin
            wordCount <= lenWord;
            if (lenWord == 16'd0) begin
              state      <= DONE;
              byte_ready <= 1'b0;
              cpu_hold   <= 1'b0;
              load_done  <= 1'b1;
            end else if (lenWord > 16'(MEMORY_DEPTH)) begin
              state      <= ERROR;
              byte_ready <= 1'b0;
              load_error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (take) begin
            byteIdx  <= byteIdx + 2'd1;
            shiftReg <= {shiftReg[15:0], byte_in};
            if (byteIdx == 2'd3) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
              mem_we     <= 1'b1;
              mem_addr   <= words_written[ADDR_WIDTH-1:0];
              mem_wdata  <= {shiftReg, byte_in};
            end
          end
        end

        WRITE: begin
          words_written <= words_written + 1'b1;
`ifdef OPCODE_CHECK_EN
          illegalSeen   <= illegalSeen | badOpcode;
`endif
          if (writtenNext == wordCount) begin
            if (finalBad) begin
              state      <= ERROR;
              load_error <= 1'b1;
            end else begin
              state     <= DONE;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end
          end else begin
            state      <= DATA;
            byte_ready <= 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          cpu_hold   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the instruction-memory interface. Receives a program as a byte stream, packs the bytes into 32-bit MIPS instruction words, and writes them through the instruction ROM/RAM write port starting at word address 0.
- Holds the processor in reset until a complete, well-formed program has been written.
- Sits between the host/UART byte source and the instruction memory, alongside the fetch path.

Parameters:
- MEMORY_DEPTH, 64, number of 32-bit words in instruction memory; maximum program length.
- ADDR_WIDTH, 6, word-address width; must satisfy 2**ADDR_WIDTH >= MEMORY_DEPTH.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begins a load session; sampled only in IDLE, DONE, ERROR
- byte_in  input  8  stream byte
- byte_valid  input  1  byte_in valid
- byte_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction memory write strobe, one-cycle pulse per word
- mem_addr  output  ADDR_WIDTH  word address for write
- mem_wdata  output  32  instruction word
- cpu_hold  output  1  keeps processor in reset while high
- load_done  output  1  program loaded successfully (level)
- load_error  output  1  session aborted (level)
- words_written  output  ADDR_WIDTH+1  words written this session
- illegal_op  output  1  sticky opcode-check flag (see Optional Feature)

Behaviour:
- Reset values: state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_error=0, words_written=0, illegal_op=0. Reset asserted mid-session aborts immediately; partially written memory is left as is.
- Byte transfer occurs only on a cycle with byte_valid && byte_ready.
- Stream format: 16-bit word count N, big-endian (LEN_HI then LEN_LO), followed by 4*N bytes. Each word is big-endian: first byte goes to [31:24], fourth byte to [7:0].
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
- IDLE: byte_ready=0. On start, go to LEN_HI and clear words_written, load_done, load_error, illegal_op, and the byte index.
- LEN_HI / LEN_LO: byte_ready=1. Capture one length byte each.
  - After LEN_LO, N==0 goes to DONE.
  - N > MEMORY_DEPTH goes to ERROR with no writes.
  - Otherwise go to DATA.
- DATA: byte_ready=1. Shift bytes into the word register. After the 4th accepted byte go to WRITE.
- WRITE: byte_ready=0. mem_we=1 for exactly one cycle, with mem_addr=words_written[ADDR_WIDTH-1:0] and mem_wdata=assembled word. This is the cycle right after the 4th byte is accepted (latency 1). words_written increments at the end of the cycle.
  - If words_written reaches N, go to DONE on the next cycle.
  - Otherwise return to DATA.
- DONE: load_done=1, cpu_hold=0, byte_ready=0. Bytes presented here are not accepted.
- ERROR: load_error=1, cpu_hold=1, byte_ready=0.
- start is ignored in LEN_HI, LEN_LO, DATA and WRITE. start in DONE or ERROR restarts the session: cpu_hold returns to 1 on the next cycle.
- cpu_hold=0 only in DONE.
- mem_addr and mem_wdata hold their last value when mem_we=0.
- The maximum legal N (N==MEMORY_DEPTH) fills the memory exactly, with the last address MEMORY_DEPTH-1. There is no wrap-around.

Optional Feature:
- Macro: OPCODE_CHECK_EN.
- Defined: in WRITE, bits [31:26] are compared against the supported set: 0x00 R-type, 0x08 addi, 0x0d ori, 0x0c andi, 0x0f lui, 0x23 lw, 0x2b sw, 0x04 beq, 0x05 bne, 0x02 j, 0x03 jal.
  - An unsupported opcode sets illegal_op (sticky until next start). The word is still written.
  - After the final write, FSM goes to ERROR instead of DONE if illegal_op=1.
- Not defined: illegal_op tied to 0 and every word is accepted.

Test Plan:
- Reset, then start; stream 00 01 20 08 00 05 -> one mem_we pulse with addr 0, wdata 0x20080005 one cycle after the 4th data byte; then load_done=1, cpu_hold=0, words_written=1.
- Stream N=3 with byte_valid toggling every other cycle -> writes at addr 0,1,2 in order, each word big-endian; byte_ready=0 during each WRITE cycle.
- Stream length 00 41 (65 > MEMORY_DEPTH=64) -> no mem_we; load_error=1, cpu_hold=1; start then restarts cleanly.
- Stream length 00 00 -> DONE two cycles after start with no writes; then N=64 -> last write at addr 63, words_written=64, load_done=1.
- Assert reset after 2 of 4 data bytes -> all outputs return to reset values; a new session then loads 0x0C000010 correctly to addr 0.
- OPCODE_CHECK_EN defined: stream N=2 with words 0x34080001 and 0xFC000000 -> both written; illegal_op=1, load_error=1, cpu_hold=1. Without the macro the same stream gives load_done=1.
